// File: rtl/mipi_csi2_rx_depacketizer.sv
// CSI-2 receive depacketizer: parses lane-merged packet headers, checks ECC and
// payload CRC-16, and streams one 24-bit pixel per payload word onto AXI-Stream.
module mipi_csi2_rx_depacketizer #(
  parameter logic [1:0] VC_ID     = 2'd0,
  parameter logic [5:0] DATA_TYPE = 6'h24
) (
  input  logic        dphy_clk_200M,
  input  logic        rst_n_200mhz,
  input  logic [31:0] rx_data,
  input  logic        rx_valid,
  input  logic        rx_sot,
  input  logic        rx_eot,
  output logic [23:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  input  logic        m_axis_tready,
  output logic        frame_start,
  output logic        frame_done,
  output logic [15:0] line_count,
  output logic        ecc_err,
  output logic        crc_err,
  output logic        trunc_err,
  output logic        overflow,
  input  logic        err_clear,
  output logic [7:0]  crc_err_cnt
);

  typedef enum logic [1:0] {IDLE = 2'd0, PAYLOAD = 2'd1, CRC = 2'd2, DISCARD = 2'd3} state_t;

  function automatic logic [5:0] ecc6(input logic [23:0] d);
    logic [5:0] p;
    p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
    p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
    p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
    p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
    p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
    p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
    return p;
  endfunction

  // Reflected form of x^16+x^12+x^5+1; bit i of the word goes in i-th (byte0 LSB first).
  function automatic logic [15:0] crc16_word(input logic [15:0] c, input logic [31:0] w);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 32; i++) begin
      r = (r >> 1) ^ ((r[0] ^ w[i]) ? 16'h8408 : 16'h0000);
    end
    return r;
  endfunction

  state_t      state_q, state_d;
  logic [13:0] wcnt_q, wcnt_d;
  logic [15:0] crc_q, crc_d;
  logic        tuser_pend_q, tuser_pend_d;
  logic [15:0] line_count_q, line_count_d;
  logic [7:0]  crc_err_cnt_q, crc_err_cnt_d;
  logic        overflow_q, overflow_d;
  logic [23:0] tdata_q, tdata_d;
  logic        tvalid_q, tvalid_d;
  logic        tlast_q, tlast_d;
  logic        tuser_q, tuser_d;
  logic        frame_start_q, frame_start_d;
  logic        frame_done_q, frame_done_d;
  logic        ecc_err_q, ecc_err_d;
  logic        crc_err_q, crc_err_d;
  logic        trunc_err_q, trunc_err_d;
  logic        overflow_set, cnt_inc;

  logic [1:0]  hdr_vc;
  logic [5:0]  hdr_dt;
  logic [15:0] hdr_wc;
  logic        is_hdr, is_word, hdr_ok, vc_match, is_short, long_ok, last_word, out_free;

  assign hdr_vc    = rx_data[7:6];
  assign hdr_dt    = rx_data[5:0];
  assign hdr_wc    = rx_data[23:8];
  assign hdr_ok    = (rx_data[31:24] == {2'b00, ecc6(rx_data[23:0])});
  assign is_hdr    = rx_valid & rx_sot;
  assign is_word   = rx_valid & ~rx_sot;
  assign vc_match  = (hdr_vc == VC_ID);
  assign is_short  = (hdr_dt < 6'h10);
  assign long_ok   = vc_match && (hdr_dt == DATA_TYPE) && (hdr_wc != 16'd0) && (hdr_wc[1:0] == 2'b00);
  assign last_word = (wcnt_q == 14'd1);
  assign out_free  = ~tvalid_q | m_axis_tready;

  always_ff @(posedge dphy_clk_200M or negedge rst_n_200mhz) begin
    if (!rst_n_200mhz) begin
      state_q       <= IDLE;
      wcnt_q        <= '0;
      crc_q         <= '0;
      tuser_pend_q  <= 1'b0;
      line_count_q  <= '0;
      crc_err_cnt_q <= '0;
      overflow_q    <= 1'b0;
      tdata_q       <= '0;
      tvalid_q      <= 1'b0;
      tlast_q       <= 1'b0;
      tuser_q       <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      ecc_err_q     <= 1'b0;
      crc_err_q     <= 1'b0;
      trunc_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      wcnt_q        <= wcnt_d;
      crc_q         <= crc_d;
      tuser_pend_q  <= tuser_pend_d;
      line_count_q  <= line_count_d;
      crc_err_cnt_q <= crc_err_cnt_d;
      overflow_q    <= overflow_d;
      tdata_q       <= tdata_d;
      tvalid_q      <= tvalid_d;
      tlast_q       <= tlast_d;
      tuser_q       <= tuser_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      ecc_err_q     <= ecc_err_d;
      crc_err_q     <= crc_err_d;
      trunc_err_q   <= trunc_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (is_hdr) begin
      if (!hdr_ok)       state_d = rx_eot ? IDLE : DISCARD;
      else if (is_short) state_d = IDLE;
      else if (long_ok)  state_d = rx_eot ? IDLE : PAYLOAD;
      else               state_d = rx_eot ? IDLE : DISCARD;
    end else if (is_word) begin
      case (state_q)
        PAYLOAD: begin
          if (last_word)   state_d = rx_eot ? IDLE : CRC;
          else if (rx_eot) state_d = IDLE;
        end
        CRC:     state_d = IDLE;
        DISCARD: if (rx_eot) state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    wcnt_d        = wcnt_q;
    crc_d         = crc_q;
    tuser_pend_d  = tuser_pend_q;
    line_count_d  = line_count_q;
    tdata_d       = tdata_q;
    tvalid_d      = tvalid_q & ~m_axis_tready;
    tlast_d       = tlast_q;
    tuser_d       = tuser_q;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    ecc_err_d     = 1'b0;
    crc_err_d     = 1'b0;
    trunc_err_d   = 1'b0;
    overflow_set  = 1'b0;
    cnt_inc       = 1'b0;

    if (is_hdr) begin
      trunc_err_d = (state_q == PAYLOAD) || (state_q == CRC);
      if (!hdr_ok) begin
        ecc_err_d = 1'b1;
      end else if (is_short) begin
        if (vc_match && hdr_dt == 6'h00) begin
          frame_start_d = 1'b1;
          line_count_d  = '0;
          tuser_pend_d  = 1'b1;
        end
        if (vc_match && hdr_dt == 6'h01) frame_done_d = 1'b1;
      end else if (long_ok) begin
        wcnt_d = hdr_wc[15:2];
        crc_d  = 16'hFFFF;
        // A long header that also ends the transmission cannot carry its payload.
        if (rx_eot) trunc_err_d = 1'b1;
      end
    end else if (is_word) begin
      if (state_q == PAYLOAD) begin
        crc_d        = crc16_word(crc_q, rx_data);
        wcnt_d       = wcnt_q - 14'd1;
        tuser_pend_d = 1'b0;
        if (out_free) begin
          tvalid_d = 1'b1;
          tdata_d  = rx_data[23:0];
          tlast_d  = last_word;
          tuser_d  = tuser_pend_q;
        end else begin
          overflow_set = 1'b1;
        end
        if (rx_eot) trunc_err_d = 1'b1;
      end else if (state_q == CRC) begin
        if (rx_data[15:0] != crc_q) begin
          crc_err_d = 1'b1;
          cnt_inc   = 1'b1;
        end
        line_count_d = line_count_q + 16'd1;
      end
    end

    // A new error in the same cycle as err_clear takes precedence.
    overflow_d = overflow_set ? 1'b1 : (err_clear ? 1'b0 : overflow_q);
    if (cnt_inc)        crc_err_cnt_d = (crc_err_cnt_q == 8'hFF) ? 8'hFF : crc_err_cnt_q + 8'd1;
    else if (err_clear) crc_err_cnt_d = '0;
    else                crc_err_cnt_d = crc_err_cnt_q;
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tuser  = tuser_q;
  assign frame_start   = frame_start_q;
  assign frame_done    = frame_done_q;
  assign line_count    = line_count_q;
  assign ecc_err       = ecc_err_q;
  assign crc_err       = crc_err_q;
  assign trunc_err     = trunc_err_q;
  assign overflow      = overflow_q;
  assign crc_err_cnt   = crc_err_cnt_q;

endmodule

// File: tb/tb_mipi_csi2_rx_depacketizer.sv
// Scoreboard bench for the CSI-2 depacketizer: stimulus pushes expected beats,
// a monitor pops and compares them on every accepted AXI-Stream transfer.
module tb_mipi_csi2_rx_depacketizer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] rx_data;
  logic        rx_valid, rx_sot, rx_eot;
  logic [23:0] tdata;
  logic        tvalid, tlast, tuser, tready;
  logic        fs, fe, ecc_e, crc_e, trunc_e, ovf, err_clear;
  logic [15:0] line_count;
  logic [7:0]  crc_cnt;

  always #5 clk = ~clk;

  mipi_csi2_rx_depacketizer dut (
    .dphy_clk_200M (clk),
    .rst_n_200mhz  (rst_n),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_sot        (rx_sot),
    .rx_eot        (rx_eot),
    .m_axis_tdata  (tdata),
    .m_axis_tvalid (tvalid),
    .m_axis_tlast  (tlast),
    .m_axis_tuser  (tuser),
    .m_axis_tready (tready),
    .frame_start   (fs),
    .frame_done    (fe),
    .line_count    (line_count),
    .ecc_err       (ecc_e),
    .crc_err       (crc_e),
    .trunc_err     (trunc_e),
    .overflow      (ovf),
    .err_clear     (err_clear),
    .crc_err_cnt   (crc_cnt)
  );

  typedef struct packed {
    logic [23:0] data;
    logic        last;
    logic        user;
  } beat_t;

  beat_t exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int beats = 0, fs_n = 0, fe_n = 0, ecc_n = 0, crc_n = 0, trunc_n = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  // Header ECC: parity bit k is the XOR of the header bits selected by mask k.
  function automatic logic [5:0] ecc_of(input logic [23:0] d);
    logic [5:0] p;
    p[0] = ^(d & 24'hF12CB7);
    p[1] = ^(d & 24'hF2555B);
    p[2] = ^(d & 24'h749A6D);
    p[3] = ^(d & 24'hB8E38E);
    p[4] = ^(d & 24'hDF03F0);
    p[5] = ^(d & 24'hEFFC00);
    return p;
  endfunction

  function automatic logic [31:0] hdr(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc);
    logic [23:0] d;
    d = {wc, vc, dt};
    return {2'b00, ecc_of(d), d};
  endfunction

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [31:0] w);
    logic [15:0] r;
    logic [7:0]  b;
    r = c;
    for (int k = 0; k < 4; k++) begin
      b = w[8*k +: 8];
      for (int j = 0; j < 8; j++) begin
        if (r[0] ^ b[0]) r = (r >> 1) ^ 16'h8408;
        else             r = r >> 1;
        b = b >> 1;
      end
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (fs)      fs_n++;
    if (fe)      fe_n++;
    if (ecc_e)   ecc_n++;
    if (crc_e)   crc_n++;
    if (trunc_e) trunc_n++;
    if (tvalid && tready) begin
      beats++;
      $display("beat %0d data=%06h last=%0b user=%0b", beats, tdata, tlast, tuser);
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL beat_unexpected: got data 0x%06h, required no beat", tdata);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        check("beat", {6'b0, tuser, tlast, tdata}, {6'b0, e.user, e.last, e.data});
      end
    end
  end

  task automatic drive(input logic [31:0] d, input logic sot, input logic eot);
    rx_data = d; rx_valid = 1'b1; rx_sot = sot; rx_eot = eot;
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_sot = 1'b0; rx_eot = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // mode: 0 = expect no beats, 1 = every word, 2 = only the first word.
  task automatic send_long(input int n, input logic [31:0] base, input bit bad_crc,
                           input int mode, input bit first_user);
    logic [15:0] c;
    logic [31:0] w;
    beat_t b;
    c = 16'hFFFF;
    drive(hdr(2'd0, 6'h24, 16'(n * 4)), 1'b1, 1'b0);
    for (int i = 0; i < n; i++) begin
      w = base + 32'(i) * 32'h01020304;
      c = crc_upd(c, w);
      if (mode == 1 || (mode == 2 && i == 0)) begin
        b.data = w[23:0]; b.last = (i == n - 1); b.user = first_user && (i == 0);
        exp_q.push_back(b);
      end
      drive(w, 1'b0, 1'b0);
    end
    drive({16'h0, bad_crc ? (c ^ 16'h0001) : c}, 1'b0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of run, required completion");
    $fatal(1);
  end

  initial begin
    int b0, f0, e0, c0, t0, s0, d0;
    beat_t b;
    logic [31:0] w;
    rst_n = 1'b0; rx_data = '0; rx_valid = 1'b0; rx_sot = 1'b0; rx_eot = 1'b0;
    tready = 1'b1; err_clear = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_flags", {23'b0, tvalid, tlast, tuser, fs, fe, ecc_e, crc_e, trunc_e, ovf}, 32'h0);
    check("rst_tdata", {8'h0, tdata}, 32'h0);
    check("rst_line_count", {16'h0, line_count}, 32'h0);
    check("rst_crc_cnt", {24'h0, crc_cnt}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    // Frame start, one good RGB888 line, frame end.
    b0 = beats; f0 = fs_n; d0 = fe_n; e0 = ecc_n; c0 = crc_n; t0 = trunc_n;
    drive(hdr(2'd0, 6'h00, 16'd1), 1'b1, 1'b1);
    send_long(4, 32'hA1B2C3D4, 1'b0, 1, 1'b1);
    drive(hdr(2'd0, 6'h01, 16'd1), 1'b1, 1'b1);
    idle(3);
    check("t1_beats", beats - b0, 4);
    check("t1_frame_start", fs_n - f0, 1);
    check("t1_frame_done", fe_n - d0, 1);
    check("t1_line_count", {16'h0, line_count}, 1);
    check("t1_errors", (ecc_n - e0) + (crc_n - c0) + (trunc_n - t0), 0);

    // Corrupted header ECC: packet dropped, block back in IDLE.
    b0 = beats; e0 = ecc_n; d0 = fe_n;
    drive(hdr(2'd0, 6'h24, 16'd8) ^ 32'h0400_0000, 1'b1, 1'b0);
    drive(32'h11223344, 1'b0, 1'b0);
    drive(32'h55667788, 1'b0, 1'b0);
    drive(32'h0000BEEF, 1'b0, 1'b1);
    drive(32'h12345678, 1'b0, 1'b0);
    drive(hdr(2'd0, 6'h01, 16'd2), 1'b1, 1'b1);
    idle(3);
    check("t2_ecc_err", ecc_n - e0, 1);
    check("t2_beats", beats - b0, 0);
    check("t2_frame_done", fe_n - d0, 1);
    check("t2_line_count", {16'h0, line_count}, 1);

    // Bad CRC once, then 256 more to reach saturation.
    b0 = beats; c0 = crc_n;
    send_long(4, 32'h0BADF00D, 1'b1, 1, 1'b0);
    idle(3);
    check("t3_beats", beats - b0, 4);
    check("t3_crc_err", crc_n - c0, 1);
    check("t3_crc_cnt", {24'h0, crc_cnt}, 1);
    for (int i = 0; i < 256; i++) send_long(1, 32'h100 + 32'(i), 1'b1, 1, 1'b0);
    idle(3);
    check("t3_crc_cnt_sat", {24'h0, crc_cnt}, 255);
    check("t3_crc_err_total", crc_n - c0, 257);
    check("t3_line_count", {16'h0, line_count}, 258);
    err_clear = 1'b1; idle(1); err_clear = 1'b0;
    check("t3_crc_cnt_clear", {24'h0, crc_cnt}, 0);

    // Sink stalled for a whole line: first beat held, rest dropped.
    b0 = beats; c0 = crc_n;
    tready = 1'b0;
    send_long(4, 32'hCAFE0001, 1'b0, 2, 1'b0);
    idle(3);
    check("t4_overflow", {31'h0, ovf}, 1);
    check("t4_held_valid", {31'h0, tvalid}, 1);
    check("t4_held_data", {8'h0, tdata}, 32'h00FE0001);
    check("t4_line_count", {16'h0, line_count}, 259);
    check("t4_crc_err", crc_n - c0, 0);
    tready = 1'b1;
    idle(2);
    check("t4_beats", beats - b0, 1);
    err_clear = 1'b1; idle(1); err_clear = 1'b0;
    check("t4_overflow_clear", {31'h0, ovf}, 0);

    // New frame-start header cuts a line short after one payload word.
    b0 = beats; f0 = fs_n; t0 = trunc_n;
    drive(hdr(2'd0, 6'h24, 16'd16), 1'b1, 1'b0);
    b.data = 24'h777777; b.last = 1'b0; b.user = 1'b0;
    exp_q.push_back(b);
    drive(32'h00777777, 1'b0, 1'b0);
    drive(hdr(2'd0, 6'h00, 16'd2), 1'b1, 1'b1);
    idle(3);
    check("t5_trunc_err", trunc_n - t0, 1);
    check("t5_frame_start", fs_n - f0, 1);
    check("t5_line_count", {16'h0, line_count}, 0);
    check("t5_beats", beats - b0, 1);

    // Reset in the middle of a line; tail words must be ignored afterwards.
    b0 = beats; e0 = ecc_n; c0 = crc_n; t0 = trunc_n; s0 = fs_n;
    drive(hdr(2'd0, 6'h24, 16'd16), 1'b1, 1'b0);
    b.data = 24'h010203; b.last = 1'b0; b.user = 1'b1;
    exp_q.push_back(b);
    drive(32'h00010203, 1'b0, 1'b0);
    rx_data = 32'h00040506; rx_valid = 1'b1;
    #6;
    rst_n = 1'b0; rx_valid = 1'b0;
    @(negedge clk);
    check("t6_rst_flags", {23'b0, tvalid, tlast, tuser, fs, fe, ecc_e, crc_e, trunc_e, ovf}, 32'h0);
    check("t6_rst_tdata", {8'h0, tdata}, 32'h0);
    check("t6_rst_line_count", {16'h0, line_count}, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(32'h00070809, 1'b0, 1'b0);
    drive(32'h000A0B0C, 1'b0, 1'b0);
    drive(32'h00001234, 1'b0, 1'b1);
    idle(3);
    check("t6_beats", beats - b0, 1);
    check("t6_line_count", {16'h0, line_count}, 0);
    check("t6_errors", (ecc_n - e0) + (crc_n - c0) + (trunc_n - t0) + (fs_n - s0), 0);
    w = 32'h00ABCDEF;
    send_long(1, w, 1'b0, 1, 1'b0);
    idle(3);
    check("t6_line_after", {16'h0, line_count}, 1);

    idle(3);
    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
